// File: rtl/sort_serializer.sv
// sort_serializer: captures a packed sorted vector and emits its elements one per handshake.
// Optional SORT_SER_ORDER_CHECK_EN adds an order_err output flagging unsorted captures.
`default_nettype none

module sort_serializer #(
  parameter int DEPTH    = 4,
  parameter int BITWIDTH = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DEPTH*BITWIDTH-1:0] din,
  input  logic                      dout_ready,
  output logic [BITWIDTH-1:0]       dout,
  output logic                      dout_valid,
  output logic                      dout_last,
  output logic                      busy,
`ifdef SORT_SER_ORDER_CHECK_EN
  output logic                      order_err,
`endif
  output logic                      load_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                      r_state;
  logic [IW-1:0]               r_idx;
  logic [DEPTH*BITWIDTH-1:0]   r_shadow;
  logic [BITWIDTH-1:0]         r_dout;
  logic                        r_valid;
  logic                        r_last;
  logic                        r_busy;
  logic                        r_load_err;

  logic [BITWIDTH-1:0]         w_elem [DEPTH];
  logic [IW-1:0]               w_idx_nxt;
  logic                        w_hs;
  logic                        w_last_hs;
  logic                        w_accept;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elem
    assign w_elem[gi] = r_shadow[gi*BITWIDTH +: BITWIDTH];
  end

  assign w_idx_nxt = r_idx + 1'b1;
  assign w_hs      = r_valid & dout_ready;
  assign w_last_hs = w_hs & (r_idx == LAST_IDX);
  // The final handshake doubles as an acceptance window so bursts chain without a bubble.
  assign w_accept  = load & ((r_state == IDLE) | w_last_hs);

`ifdef SORT_SER_ORDER_CHECK_EN
  logic r_order_err;
  logic w_order;

  always_comb begin
    w_order = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (din[i*BITWIDTH +: BITWIDTH] > din[(i+1)*BITWIDTH +: BITWIDTH]) begin
        w_order = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_order_err <= 1'b0;
    end else if (w_accept) begin
      r_order_err <= w_order;
    end
  end

  assign order_err = r_order_err;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_dout     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (w_accept) begin
      r_state  <= SEND;
      r_idx    <= '0;
      r_shadow <= din;
      r_dout   <= din[BITWIDTH-1:0];
      r_valid  <= 1'b1;
      r_last   <= 1'b0;
      r_busy   <= 1'b1;
    end else if (r_state == SEND) begin
      if (load) begin
        r_load_err <= 1'b1;
      end
      if (w_hs) begin
        if (r_idx == LAST_IDX) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
        end else begin
          r_idx  <= w_idx_nxt;
          r_dout <= w_elem[w_idx_nxt];
          r_last <= (w_idx_nxt == LAST_IDX);
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign dout_last  = r_last;
  assign busy       = r_busy;
  assign load_err   = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_sort_serializer.sv
// tb_sort_serializer: directed self-checking bench for sort_serializer (DEPTH=4, BITWIDTH=3).
`default_nettype none

module tb_sort_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [11:0] din = '0;
  logic        dout_ready = 1'b0;
  logic [2:0]  dout;
  logic        dout_valid;
  logic        dout_last;
  logic        busy;
  logic        load_err;
`ifdef SORT_SER_ORDER_CHECK_EN
  logic        order_err;
`endif

  int total = 0;
  int bad   = 0;

  sort_serializer #(.DEPTH(4), .BITWIDTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .din(din),
    .dout_ready(dout_ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_last(dout_last),
    .busy(busy),
`ifdef SORT_SER_ORDER_CHECK_EN
    .order_err(order_err),
`endif
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  // {dout, dout_valid, dout_last, busy}
  function automatic logic [5:0] obs();
    return {dout, dout_valid, dout_last, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    total++;
    if ({obs(), load_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: got %b expected %b", {obs(), load_err}, 7'b0);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic_burst();
    logic [5:0] exp [5];
    exp[0] = {3'd1, 3'b101};
    exp[1] = {3'd2, 3'b101};
    exp[2] = {3'd3, 3'b101};
    exp[3] = {3'd4, 3'b111};
    exp[4] = {3'd4, 3'b000};
    load = 1'b1; din = 12'h8D1; dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = 1'b0;
      total++;
      if (obs() !== exp[i]) begin
        bad++;
        $display("FAIL basic_burst[%0d]: got %b expected %b", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] exp [8];
    logic       rdy [8];
    exp[0] = {3'd1, 3'b101}; rdy[0] = 1'b1;
    exp[1] = {3'd2, 3'b101}; rdy[1] = 1'b1;
    exp[2] = {3'd3, 3'b101}; rdy[2] = 1'b0;
    exp[3] = {3'd3, 3'b101}; rdy[3] = 1'b0;
    exp[4] = {3'd3, 3'b101}; rdy[4] = 1'b0;
    exp[5] = {3'd3, 3'b101}; rdy[5] = 1'b1;
    exp[6] = {3'd4, 3'b111}; rdy[6] = 1'b1;
    exp[7] = {3'd4, 3'b000}; rdy[7] = 1'b1;
    load = 1'b1; din = 12'h8D1; dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      load = 1'b0;
      total++;
      if (obs() !== exp[i]) begin
        bad++;
        $display("FAIL backpressure[%0d]: got %b expected %b", i, obs(), exp[i]);
      end
      dout_ready = rdy[i];
    end
    dout_ready = 1'b1;
  endtask

  task automatic test_load_err();
    logic [5:0] exp [5];
    exp[0] = {3'd1, 3'b101};
    exp[1] = {3'd2, 3'b101};
    exp[2] = {3'd3, 3'b101};
    exp[3] = {3'd4, 3'b111};
    exp[4] = {3'd4, 3'b000};
    total++;
    if (load_err !== 1'b0) begin
      bad++;
      $display("FAIL load_err_initial: got %b expected 0", load_err);
    end
    load = 1'b1; din = 12'h8D1; dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      load = (i == 1);
      din  = (i == 1) ? 12'hFFF : 12'h8D1;
      total++;
      if (obs() !== exp[i]) begin
        bad++;
        $display("FAIL load_err_burst[%0d]: got %b expected %b", i, obs(), exp[i]);
      end
    end
    tick();
    total++;
    if (load_err !== 1'b1) begin
      bad++;
      $display("FAIL load_err_sticky: got %b expected 1", load_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp [9];
    exp[0] = {3'd1, 3'b101};
    exp[1] = {3'd2, 3'b101};
    exp[2] = {3'd3, 3'b101};
    exp[3] = {3'd4, 3'b111};
    exp[4] = {3'd7, 3'b101};
    exp[5] = {3'd7, 3'b101};
    exp[6] = {3'd7, 3'b101};
    exp[7] = {3'd7, 3'b111};
    exp[8] = {3'd7, 3'b000};
    load = 1'b1; din = 12'h8D1; dout_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      load = (i == 3);
      din  = (i == 3) ? 12'hFFF : 12'h8D1;
      total++;
      if (obs() !== exp[i]) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs(), exp[i]);
      end
    end
  endtask

  task automatic test_reset_midburst();
    load = 1'b1; din = 12'h8D1; dout_ready = 1'b1;
    tick();
    load = 1'b0;
    tick();
    total++;
    if (obs() !== {3'd2, 3'b101}) begin
      bad++;
      $display("FAIL midburst_pre: got %b expected %b", obs(), {3'd2, 3'b101});
    end
    reset = 1'b1;
    #2;
    total++;
    if ({obs(), load_err} !== 7'b0) begin
      bad++;
      $display("FAIL midburst_async: got %b expected %b", {obs(), load_err}, 7'b0);
    end
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs() !== 6'b0) begin
        bad++;
        $display("FAIL midburst_after[%0d]: got %b expected %b", i, obs(), 6'b0);
      end
    end
    // Load presented on the first edge following a fresh reset release.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    load = 1'b1; din = 12'hFFF;
    tick();
    load = 1'b0;
    total++;
    if (obs() !== {3'd7, 3'b101}) begin
      bad++;
      $display("FAIL first_edge_load: got %b expected %b", obs(), {3'd7, 3'b101});
    end
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (obs() !== {3'd7, 3'b000}) begin
      bad++;
      $display("FAIL first_edge_done: got %b expected %b", obs(), {3'd7, 3'b000});
    end
  endtask

`ifdef SORT_SER_ORDER_CHECK_EN
  task automatic test_order_check();
    load = 1'b1; din = 12'h8CB; dout_ready = 1'b1;
    tick();
    load = 1'b0;
    total++;
    if (order_err !== 1'b1 || obs() !== {3'd3, 3'b101}) begin
      bad++;
      $display("FAIL order_unsorted: got err=%b out=%b expected err=1 out=%b", order_err, obs(), {3'd3, 3'b101});
    end
    tick(); tick();
    load = 1'b1; din = 12'h8D1;
    tick();
    total++;
    if (order_err !== 1'b1 || dout_last !== 1'b1) begin
      bad++;
      $display("FAIL order_hold: got err=%b last=%b expected 1 1", order_err, dout_last);
    end
    tick();
    load = 1'b0;
    total++;
    if (order_err !== 1'b0 || obs() !== {3'd1, 3'b101}) begin
      bad++;
      $display("FAIL order_sorted: got err=%b out=%b expected err=0 out=%b", order_err, obs(), {3'd1, 3'b101});
    end
    for (int i = 0; i < 4; i++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_load_err();
    test_back_to_back();
    test_reset_midburst();
`ifdef SORT_SER_ORDER_CHECK_EN
    test_order_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of elements per packed vector (>=2).
REQ-002 SHALL have parameter BITWIDTH, default 3, width of one element in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  request to capture din.
REQ-006 SHALL have port din  input  DEPTH*BITWIDTH  packed sorted vector from the sorter; element i at bits [i*BITWIDTH +: BITWIDTH].
REQ-007 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-008 SHALL have port dout  output  BITWIDTH  current element.
REQ-009 SHALL have port dout_valid  output  1  dout holds a valid element.
REQ-010 SHALL have port dout_last  output  1  dout is element DEPTH-1 of the burst.
REQ-011 SHALL have port busy  output  1  burst in progress.
REQ-012 SHALL have port load_err  output  1  sticky: load was dropped.

Function
REQ-013 SHALL implement two states: IDLE and SEND; all outputs registered.
REQ-014 A load is accepted in IDLE, or in SEND during the cycle in which element DEPTH-1 handshakes (dout_valid & dout_ready).
REQ-015 On an accepted load, SHALL capture din into a shadow register, set index to 0, and enter SEND; dout_valid=1 with dout=element 0 on the next cycle (latency 1).
REQ-016 In SEND, dout SHALL equal shadow element[index]; dout_valid=1; busy=1.
REQ-017 On handshake with index<DEPTH-1, SHALL increment index; the next element appears the following cycle.
REQ-018 With dout_ready=0, dout, dout_valid, dout_last and index SHALL hold unchanged.
REQ-019 dout_last SHALL be 1 exactly when dout_valid=1 and index==DEPTH-1.
REQ-020 On handshake at index DEPTH-1 without an accepted load, SHALL return to IDLE: dout_valid=0, dout_last=0, busy=0 next cycle; dout keeps its last value.
REQ-021 On handshake at index DEPTH-1 with load=1, SHALL capture the new din and present its element 0 next cycle with no bubble.
REQ-022 A load in SEND outside the REQ-014 window SHALL be ignored and set load_err=1; load_err clears only on reset.
REQ-023 The index counter SHALL be $clog2(DEPTH) bits wide and never exceed DEPTH-1.

Reset
REQ-024 While reset=1, regardless of clk: state=IDLE, index=0, shadow=0, dout=0, dout_valid=0, dout_last=0, busy=0, load_err=0 (and order_err=0 when present).
REQ-025 Reset asserted mid-burst SHALL abort the burst; no remaining elements are emitted after release.
REQ-026 A load on the first clk edge after reset deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro SORT_SER_ORDER_CHECK_EN defined: SHALL add output order_err (1 bit), registered at load acceptance as 1 if any element[i] > element[i+1] in the captured din, else 0; held until the next accepted load or reset.
REQ-028 Macro undefined: order_err port and its comparison logic SHALL be absent; all other behaviour identical.

Verification (DEPTH=4, BITWIDTH=3)
REQ-029 Reset released, load=1 with din=12'h8D1 (1,2,3,4), dout_ready=1 -> dout 1,2,3,4 on cycles 1..4 after load, dout_last=1 only with 4, busy=0 on cycle 5.
REQ-030 Same burst, dout_ready=0 for 3 cycles while dout=3 -> dout holds 3 with dout_valid=1, then 4 with dout_last one cycle after dout_ready returns to 1.
REQ-031 load pulsed while dout=2 -> burst continues 3,4 unchanged; load_err=1 and stays 1 until reset.
REQ-032 load=1 with din=12'hFFF in the cycle element 4 handshakes -> next cycle dout=7, dout_valid=1, no idle cycle between bursts.
REQ-033 reset pulsed while dout=2 -> all outputs 0 immediately; after release, no further dout_valid until the next load.
REQ-034 SORT_SER_ORDER_CHECK_EN defined, load din=12'h8CB (elements 3,1,3,4) -> order_err=1 one cycle after load; subsequent load of 12'h8D1 -> order_err=0.
